// File: rtl/simple_processor_pkg.sv
// Shared types for the issue path: ALU function encoding, instruction layout
// and the decode helper that folds the unused function codes onto INVALID.
package simple_processor_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNC_W     = 3;

    localparam int unsigned FUNC_MSB = 31;
    localparam int unsigned FUNC_LSB = 29;
    localparam int unsigned RD_MSB   = 28;
    localparam int unsigned RD_LSB   = 24;
    localparam int unsigned RS1_MSB  = 23;
    localparam int unsigned RS1_LSB  = 19;
    localparam int unsigned RS2_MSB  = 18;
    localparam int unsigned RS2_LSB  = 14;

    typedef enum logic [FUNC_W-1:0] {
        FUNC_AND     = 3'd0,
        FUNC_OR      = 3'd1,
        FUNC_XOR     = 3'd2,
        FUNC_NOT     = 3'd3,
        FUNC_INVALID = 3'd4
    } func_t;

    typedef struct packed {
        logic [FUNC_W-1:0]     func;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [RS2_LSB-1:0]    rsvd;
    } instr_t;

    // Codes 4..7 all collapse onto INVALID.
    function automatic func_t decode_func(input logic [FUNC_W-1:0] raw);
        return raw[FUNC_W-1] ? FUNC_INVALID : func_t'(raw);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero. Writeback bypass is handled by the caller.
module reg_file
    import simple_processor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1_c,
    output logic [DATA_WIDTH-1:0] rdata2_c,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1_c = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2_c = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage ahead of the ALU: decodes, reads operands with writeback bypass,
// tracks pending destinations and presents one registered op at a time.
module operand_fetch
    import simple_processor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [INSTR_W-1:0]    instr_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output func_t                 func_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic                  illegal_o
);

    logic [FUNC_W-1:0]     func_raw;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    func_t                 func_dec_c;
    logic                  func_valid_c;
    logic                  unused_rsvd;

    assign func_raw     = instr_i[FUNC_MSB:FUNC_LSB];
    assign rd           = instr_i[RD_MSB:RD_LSB];
    assign rs1          = instr_i[RS1_MSB:RS1_LSB];
    assign rs2          = instr_i[RS2_MSB:RS2_LSB];
    assign unused_rsvd  = ^instr_i[RS2_LSB-1:0];
    assign func_dec_c   = decode_func(func_raw);
    assign func_valid_c = (func_dec_c != FUNC_INVALID);

    logic [DATA_WIDTH-1:0] rf_rdata1_c;
    logic [DATA_WIDTH-1:0] rf_rdata2_c;

    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_reg_file (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .raddr1   (rs1),
        .raddr2   (rs2),
        .rdata1_c (rf_rdata1_c),
        .rdata2_c (rf_rdata2_c),
        .we       (wb_en_i),
        .waddr    (wb_addr_i),
        .wdata    (wb_data_i)
    );

    logic [DATA_WIDTH-1:0] rs1_byp_c;
    logic [DATA_WIDTH-1:0] rs2_byp_c;

    assign rs1_byp_c = (wb_en_i && (wb_addr_i == rs1) && (rs1 != '0)) ? wb_data_i : rf_rdata1_c;
    assign rs2_byp_c = (wb_en_i && (wb_addr_i == rs2) && (rs2 != '0)) ? wb_data_i : rf_rdata2_c;

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] wb_mask_c;
    logic [NUM_REGS-1:0] set_mask_c;
    logic [NUM_REGS-1:0] eff_pend_c;
    logic                hazard_c;
    logic                accept_c;

    // A writeback landing this cycle already resolves its register's hazard.
    always_comb begin
        wb_mask_c = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            wb_mask_c[i] = wb_en_i && (wb_addr_i == REG_ADDR_W'(i));
        end
    end

    assign eff_pend_c = pending_q & ~wb_mask_c;
    assign hazard_c   = eff_pend_c[rs1]
                     || ((func_dec_c != FUNC_NOT) && eff_pend_c[rs2])
                     || eff_pend_c[rd];

    assign instr_ready_o = !srst_i && !hazard_c && (!op_valid_o || op_ready_i);
    assign accept_c      = instr_valid_i && instr_ready_o;

    always_comb begin
        set_mask_c = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            set_mask_c[i] = accept_c && func_valid_c && (rd == REG_ADDR_W'(i));
        end
    end

    // Set is applied after clear so a same-index collision leaves the bit set.
    assign pending_d = (pending_q & ~wb_mask_c) | set_mask_c;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pending_q  <= '0;
            op_valid_o <= 1'b0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            func_o     <= FUNC_AND;
            rd_addr_o  <= '0;
            illegal_o  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (accept_c) begin
                op_valid_o <= 1'b1;
                rs1_data_o <= rs1_byp_c;
                rs2_data_o <= rs2_byp_c;
                func_o     <= func_dec_c;
                rd_addr_o  <= rd;
                if (!func_valid_c) begin
                    illegal_o <= 1'b1;
                end
            end else if (op_ready_i) begin
                op_valid_o <= 1'b0;
            end
        end
    end

endmodule
